cordic_ctrl: RTL and testbench



---
 rtl/cordic_pkg.sv | 51 +++++
 rtl/cordic_gain_mul.sv | 36 +++
 rtl/cordic_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cordic_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared encodings and constants for the CORDIC command controller.
package cordic_pkg;

  localparam int FRAC_BITS        = 16;
  localparam int K_INV_CIRCULAR   = 39797;
  localparam int K_INV_HYPERBOLIC = 79134;

  typedef enum logic [2:0] {
    OP_SINCOS   = 3'd0,
    OP_ATANMAG  = 3'd1,
    OP_MUL      = 3'd2,
    OP_DIV      = 3'd3,
    OP_SINHCOSH = 3'd4,
    OP_ATANH    = 3'd5
  } opcode_e;

  localparam logic [1:0] COORD_LINEAR     = 2'b00;
  localparam logic [1:0] COORD_CIRCULAR   = 2'b01;
  localparam logic [1:0] COORD_HYPERBOLIC = 2'b11;
  localparam logic       MODE_ROTATION    = 1'b0;
  localparam logic       MODE_VECTORING   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CORRECT, S_RESP
  } state_e;

  typedef struct packed {
    logic       mode_op;
    logic [1:0] mode_coord;
  } core_mode_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_ATANH;
  endfunction

  function automatic core_mode_t op_mode(input logic [2:0] op);
    core_mode_t m;
    m = '0;
    case (op)
      OP_SINCOS:   m = '{MODE_ROTATION,  COORD_CIRCULAR};
      OP_ATANMAG:  m = '{MODE_VECTORING, COORD_CIRCULAR};
      OP_MUL:      m = '{MODE_ROTATION,  COORD_LINEAR};
      OP_DIV:      m = '{MODE_VECTORING, COORD_LINEAR};
      OP_SINHCOSH: m = '{MODE_ROTATION,  COORD_HYPERBOLIC};
      OP_ATANH:    m = '{MODE_VECTORING, COORD_HYPERBOLIC};
      default:     m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cordic_gain_mul.sv
// Signed Q16.16 gain multiply: full 2*WIDTH product, >>>FRAC_BITS, truncated, registered.
module cordic_gain_mul
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic             out_vld
);

  localparam int STAGES = 1;

  logic signed [2*WIDTH-1:0] prod;
  logic [STAGES:0]           vld_pipe;

  assign prod        = $signed(a) * $signed(b);
  assign vld_pipe[0] = in_vld;
  assign out_vld     = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      p                  <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      // Taking the slice above FRAC_BITS is the arithmetic shift; upper bits drop (no saturation).
      if (in_vld) p <= prod[FRAC_BITS +: WIDTH];
    end
  end

endmodule

// File: rtl/cordic_ctrl.sv
// Request/response front end for the iterative CORDIC core: opcode mapping,
// start pulse, completion wait with timeout, and circular gain correction.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TAG_W-1:0] resp_tag,
  output logic [WIDTH-1:0] resp_r0,
  output logic [WIDTH-1:0] resp_r1,
  output logic             resp_err,
  output logic             core_enable,
  output logic             core_mode_op,
  output logic [1:0]       core_mode_coord,
  output logic [WIDTH-1:0] core_x,
  output logic [WIDTH-1:0] core_y,
  output logic [WIDTH-1:0] core_z,
  input  logic [WIDTH-1:0] core_x_out,
  input  logic [WIDTH-1:0] core_y_out,
  input  logic [WIDTH-1:0] core_z_out,
  input  logic             core_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic             err;
  } resp_t;

  state_e           state, nxt;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  resp_t            resp_q;
  core_mode_t       mode_q;
  logic [WIDTH-1:0] map_x, map_y, map_z;
  logic [WIDTH-1:0] cap_r0, cap_r1;
  logic [WIDTH-1:0] mul_p;
  logic             mul_vld;
  logic             accept, capture, tmo;

  assign accept  = (state == S_IDLE) && req_valid;
  assign capture = (state == S_WAIT) && core_valid;
  assign tmo     = (state == S_WAIT) && !core_valid && (cnt == CNT_W'(TIMEOUT - 1));

  // Operand mapping from the incoming request
  always_comb begin
    map_x = '0;
    map_y = '0;
    map_z = '0;
    case (req_op)
      OP_SINCOS:   begin map_x = WIDTH'(K_INV_CIRCULAR);   map_z = req_a; end
      OP_SINHCOSH: begin map_x = WIDTH'(K_INV_HYPERBOLIC); map_z = req_a; end
      OP_MUL:      begin map_x = req_a;                    map_z = req_b; end
      OP_ATANMAG, OP_DIV, OP_ATANH: begin map_x = req_a; map_y = req_b; end
      default: ;
    endcase
  end

  // Result selection from the core outputs for the latched op
  always_comb begin
    cap_r0 = '0;
    cap_r1 = '0;
    case (op_q)
      OP_SINCOS, OP_SINHCOSH: begin cap_r0 = core_x_out; cap_r1 = core_y_out; end
      OP_MUL:                       cap_r0 = core_y_out;
      OP_ATANMAG, OP_DIV, OP_ATANH: cap_r0 = core_z_out;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (req_valid) nxt = op_legal(req_op) ? S_ISSUE : S_RESP;
      S_ISSUE:   nxt = S_WAIT;
      S_WAIT: begin
        if (core_valid) nxt = (op_q == OP_ATANMAG) ? S_CORRECT : S_RESP;
        else if (tmo)   nxt = S_RESP;
      end
      S_CORRECT: nxt = S_RESP;
      S_RESP:    if (resp_ready) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == S_IDLE);
    core_enable = (state == S_ISSUE);
    resp_valid  = (state == S_RESP);
  end

  // Core mode/operands are loaded on accept and held until the next legal request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      mode_q <= '0;
      core_x <= '0;
      core_y <= '0;
      core_z <= '0;
    end else if (accept) begin
      op_q <= req_op;
      if (op_legal(req_op)) begin
        mode_q <= op_mode(req_op);
        core_x <= map_x;
        core_y <= map_y;
        core_z <= map_z;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state == S_ISSUE)  cnt <= '0;
    else if (state == S_WAIT)   cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
    end else if (accept) begin
      resp_q.tag <= req_tag;
      resp_q.err <= !op_legal(req_op);
      resp_q.r0  <= '0;
      resp_q.r1  <= '0;
    end else if (capture) begin
      resp_q.r0 <= cap_r0;
      resp_q.r1 <= cap_r1;
    end else if (tmo) begin
      resp_q.err <= 1'b1;
    end else if (state == S_CORRECT && mul_vld) begin
      resp_q.r1 <= mul_p;
    end
  end

  // Magnitude correction: the multiply launches on capture so its result is ready in CORRECT.
  cordic_gain_mul #(.WIDTH(WIDTH)) u_gain (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (capture && (op_q == OP_ATANMAG)),
    .a      (core_x_out),
    .b      (WIDTH'(K_INV_CIRCULAR)),
    .p      (mul_p),
    .out_vld(mul_vld)
  );

  assign core_mode_op    = mode_q.mode_op;
  assign core_mode_coord = mode_q.mode_coord;
  assign resp_tag        = resp_q.tag;
  assign resp_r0         = resp_q.r0;
  assign resp_r1         = resp_q.r1;
  assign resp_err        = resp_q.err;

endmodule

// File: tb/tb_cordic_ctrl.sv
// Scoreboard bench for cordic_ctrl with a scripted stand-in for the CORDIC core.
module tb_cordic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [3:0]  req_tag = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [3:0]  resp_tag;
  logic [31:0] resp_r0, resp_r1;
  logic        resp_err;
  logic        core_enable, core_mode_op;
  logic [1:0]  core_mode_coord;
  logic [31:0] core_x, core_y, core_z;
  logic [31:0] core_x_out = '0, core_y_out = '0, core_z_out = '0;
  logic        core_valid = 1'b0;

  cordic_ctrl #(.WIDTH(32), .TAG_W(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_r0(resp_r0), .resp_r1(resp_r1), .resp_err(resp_err),
    .core_enable(core_enable), .core_mode_op(core_mode_op), .core_mode_coord(core_mode_coord),
    .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_x_out(core_x_out), .core_y_out(core_y_out), .core_z_out(core_z_out),
    .core_valid(core_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] tag; logic [31:0] r0, r1; logic err; } exp_t;
  typedef struct { logic mop; logic [1:0] crd; logic [31:0] x, y, z; } cfg_t;
  typedef struct { logic [31:0] xo, yo, zo; int lat; bit mute; } reply_t;

  exp_t   exp_q[$];
  cfg_t   cfg_q[$];
  reply_t rep_q[$];
  int     checks = 0, fails = 0;
  int     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every accepted response against the scoreboard head
  exp_t me;
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      chk("resp_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("resp_tag", 32'(resp_tag), 32'(me.tag));
        chk("resp_r0",  resp_r0, me.r0);
        chk("resp_r1",  resp_r1, me.r1);
        chk("resp_err", 32'(resp_err), 32'(me.err));
      end
    end
  end

  // Core stand-in: checks the issued mode/operands and replies after a scripted latency
  initial begin : core_stub
    cfg_t   c;
    reply_t r;
    forever begin
      @(negedge clk);
      if (core_enable) begin
        chk("enable_expected", 32'(cfg_q.size() > 0), 1);
        if (cfg_q.size() > 0) begin
          c = cfg_q.pop_front();
          chk("core_mode_op",    32'(core_mode_op),    32'(c.mop));
          chk("core_mode_coord", 32'(core_mode_coord), 32'(c.crd));
          chk("core_x", core_x, c.x);
          chk("core_y", core_y, c.y);
          chk("core_z", core_z, c.z);
        end
        r = '{xo: 0, yo: 0, zo: 0, lat: 1, mute: 1'b1};
        if (rep_q.size() > 0) r = rep_q.pop_front();
        @(posedge clk); #1;
        chk("enable_one_cycle", 32'(core_enable), 0);
        if (!r.mute) begin
          for (int i = 1; i < r.lat; i++) begin @(posedge clk); #1; end
          core_x_out = r.xo; core_y_out = r.yo; core_z_out = r.zo;
          core_valid = 1'b1;
          @(posedge clk); #1;
          core_valid = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] tag, input logic [31:0] a, b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_tag = tag; req_a = a; req_b = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("req_accepted", 32'(ok), 1);
    if (ok) begin @(posedge clk); #1; end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("resp_drained", 32'(ok), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input logic [2:0] op, input logic [3:0] tag, input logic [31:0] a, b,
                     input logic mop, input logic [1:0] crd, input logic [31:0] cx, cy, cz,
                     input logic [31:0] xo, yo, zo, input int lat, input logic [31:0] e0, e1);
    cfg_q.push_back('{mop, crd, cx, cy, cz});
    rep_q.push_back('{xo, yo, zo, lat, 1'b0});
    exp_q.push_back('{tag, e0, e1, 1'b0});
    send(op, tag, a, b);
    drain();
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_req_ready"},   32'(req_ready), 1);
    chk({pfx, "_resp_valid"},  32'(resp_valid), 0);
    chk({pfx, "_resp_err"},    32'(resp_err), 0);
    chk({pfx, "_core_enable"}, 32'(core_enable), 0);
    chk({pfx, "_resp_tag"},    32'(resp_tag), 0);
    chk({pfx, "_resp_r0"},     resp_r0, 0);
    chk({pfx, "_resp_r1"},     resp_r1, 0);
    chk({pfx, "_core_mode"},   32'({core_mode_op, core_mode_coord}), 0);
    chk({pfx, "_core_xyz"},    core_x | core_y | core_z, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : stim
    int t0, t1;
    logic [31:0] s_r0;
    logic [3:0]  s_tag;
    bit ok;
    repeat (2) @(posedge clk); #1;
    check_reset("reset");
    rst_n = 1'b1;

    //   op tag   A        B        mop crd    cx      cy     cz      xo            yo     zo      lat e0            e1
    run(0, 3,  0,        0,        0, 2'b01, 39797,  0,     0,      65530,        3,     5,      16, 65530,        3);
    run(1, 9,  65536,    65536,    1, 2'b01, 65536,  65536, 0,      152625,       2,     51472,  16, 51472,        92682);
    run(1, 10, -65536,   0,        1, 2'b01, -65536, 0,     0,      32'hFFFFFFFF, 7,     205887, 3,  205887,       32'hFFFFFFFF);
    run(1, 8,  100,      0,        1, 2'b01, 100,    0,     0,      65536,        0,     0,      1,  0,            39797);
    run(2, 1,  131072,   32768,    0, 2'b00, 131072, 0,     32768,  131072,       65535, 1,      16, 65535,        0);
    run(3, 2,  262144,   65536,    1, 2'b00, 262144, 65536, 0,      262144,       3,     16383,  16, 16383,        0);
    run(4, 4,  32768,    0,        0, 2'b11, 79134,  0,     32768,  73932,        34145, 9,      16, 73932,        34145);
    run(5, 6,  65536,    32768,    1, 2'b11, 65536,  32768, 0,      1,            2,     35999,  5,  35999,        0);

    // Illegal opcodes: immediate error response, core never started
    exp_q.push_back('{4'd5, 0, 0, 1'b1});
    send(3'd7, 4'd5, 32'h1111, 32'h2222);
    chk("illegal_next_cycle_valid", 32'(resp_valid), 1);
    drain();
    exp_q.push_back('{4'd7, 0, 0, 1'b1});
    send(3'd6, 4'd7, 32'h1234, 32'h5678);
    drain();

    // Silent core: error after the WAIT budget, then a normal request
    cfg_q.push_back('{1'b0, 2'b01, 39797, 0, 1000});
    rep_q.push_back('{0, 0, 0, 1, 1'b1});
    exp_q.push_back('{4'd11, 0, 0, 1'b1});
    send(3'd0, 4'd11, 1000, 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (core_enable) begin ok = 1'b1; break; end end
    t0 = cyc;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin @(negedge clk); if (resp_valid) begin ok = 1'b1; break; end end
    end
    t1 = cyc;
    chk("timeout_seen", 32'(ok), 1);
    chk("timeout_latency", 32'(t1 - t0), 65);
    drain();
    run(2, 12, 65536, 98304, 0, 2'b00, 65536, 0, 98304, 65536, 98304, 0, 4, 98304, 0);

    // Backpressure: response held for 10 cycles
    resp_ready = 1'b0;
    cfg_q.push_back('{1'b1, 2'b00, 262144, 65536, 0});
    rep_q.push_back('{262144, 0, 16384, 6, 1'b0});
    exp_q.push_back('{4'd13, 16384, 0, 1'b0});
    send(3'd3, 4'd13, 262144, 65536);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (resp_valid) begin ok = 1'b1; break; end end
    chk("bp_resp_seen", 32'(ok), 1);
    s_r0 = resp_r0; s_tag = resp_tag;
    chk("bp_initial_r0", s_r0, 16384);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 1);
      chk("bp_r0_stable", resp_r0, s_r0);
      chk("bp_tag_stable", 32'(resp_tag), 32'(s_tag));
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drain();

    // Reset during WAIT: no response; the late core_valid lands in IDLE and is ignored
    cfg_q.push_back('{1'b0, 2'b01, 39797, 0, 5000});
    rep_q.push_back('{32'h0BAD, 32'h0BAD, 32'h0BAD, 20, 1'b0});
    send(3'd0, 4'd14, 5000, 0);
    repeat (5) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    run(2, 15, 65536, 65536, 0, 2'b00, 65536, 0, 65536, 65536, 65536, 0, 2, 65536, 0);

    chk("cfg_q_empty", 32'(cfg_q.size()), 0);
    chk("rep_q_empty", 32'(rep_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
